// File: rtl/dff_share_arb.sv
// Round-robin arbiter and write/verify sequencer for one shared single-bit flop.
// Optional grant lock is enabled by defining DFF_ARB_LOCK_EN (adds the lock_i port).
module dff_share_arb #(
  parameter int NREQ      = 4,
  parameter int RETRY_MAX = 2
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] wdata_i,
`ifdef DFF_ARB_LOCK_EN
  input  logic [NREQ-1:0] lock_i,
`endif
  output logic [NREQ-1:0] gnt_o,
  output logic [NREQ-1:0] ack_o,
  output logic            err_o,
  output logic            busy_o,
  output logic            d_o,
  input  logic            q_i
);

  localparam int          PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned N    = NREQ;
  localparam logic [2:0]  RMAX = 3'(RETRY_MAX);

  typedef enum logic [1:0] {IDLE, WRITE, CHECK, RESP} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            d_q, d_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [2:0]      retry_q, retry_d;
`ifdef DFF_ARB_LOCK_EN
  logic            lock_q, lock_d;
`endif

  logic            found;
  logic [PW-1:0]   pick;
  int unsigned     idx;

  // A held lock re-grants the previous winner ahead of the round-robin search.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
`ifdef DFF_ARB_LOCK_EN
    if (lock_q && req_i[win_q]) begin
      found = 1'b1;
      pick  = win_q;
    end
`endif
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr_q) + i) % N;
      if (!found && req_i[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    d_d     = d_q;
    err_d   = err_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    retry_d = retry_q;
`ifdef DFF_ARB_LOCK_EN
    lock_d  = lock_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          d_d         = wdata_i[pick];
          win_d       = pick;
          retry_d     = '0;
          state_d     = WRITE;
`ifdef DFF_ARB_LOCK_EN
          if (!lock_i[pick]) lock_d = 1'b0;
`endif
        end
      end
      WRITE: state_d = CHECK;
      CHECK: begin
        if (q_i == d_q) begin
          ack_d   = gnt_q;
          state_d = RESP;
        end else if (retry_q < RMAX) begin
          retry_d = retry_q + 3'd1;
          state_d = WRITE;
        end else begin
          err_d   = 1'b1;
          ack_d   = gnt_q;
          state_d = RESP;
        end
      end
      RESP: begin
        gnt_d   = '0;
        state_d = IDLE;
        ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
`ifdef DFF_ARB_LOCK_EN
        lock_d  = lock_i[win_q];
        if (lock_i[win_q]) ptr_d = ptr_q;
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      d_q     <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      win_q   <= '0;
      retry_q <= '0;
`ifdef DFF_ARB_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      d_q     <= d_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      retry_q <= retry_d;
`ifdef DFF_ARB_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

  assign gnt_o  = gnt_q;
  assign ack_o  = ack_q;
  assign err_o  = err_q;
  assign busy_o = busy_q;
  assign d_o    = d_q;

endmodule

// File: tb/tb_dff_share_arb.sv
// Directed bench for dff_share_arb with a model of the shared flop and a stuck-at-0 override on q.
module tb_dff_share_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] wdata = '0;
`ifdef DFF_ARB_LOCK_EN
  logic [3:0] lock = '0;
`endif
  logic [3:0] gnt, ack;
  logic       err, busy, d, q;
  logic       q_ff;
  logic       stuck = 1'b0;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) q_ff <= 1'b0;
    else     q_ff <= d;

  assign q = stuck ? 1'b0 : q_ff;

  dff_share_arb #(.NREQ(4), .RETRY_MAX(2)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .req_i   (req),
    .wdata_i (wdata),
`ifdef DFF_ARB_LOCK_EN
    .lock_i  (lock),
`endif
    .gnt_o   (gnt),
    .ack_o   (ack),
    .err_o   (err),
    .busy_o  (busy),
    .d_o     (d),
    .q_i     (q)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_gnt;
    // Reset values
    tick(); tick();
    check("rst_gnt", gnt, 4'b0000);
    check("rst_ack", ack, 4'b0000);
    check("rst_d", d, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    // Single write from requester 2; req dropped right after grant
    req = 4'b0100; wdata = 4'b0100;
    tick();
    check("sw_gnt", gnt, 4'b0100);
    check("sw_d", d, 1'b1);
    check("sw_busy", busy, 1'b1);
    check("sw_ack_w", ack, 4'b0000);
    req = 4'b0000; wdata = 4'b0000;
    tick();
    check("sw_q", q, 1'b1);
    check("sw_ack_c", ack, 4'b0000);
    tick();
    check("sw_ack_r", ack, 4'b0100);
    check("sw_err", err, 1'b0);
    tick();
    check("sw_ack_i", ack, 4'b0000);
    check("sw_busy_i", busy, 1'b0);
    check("sw_gnt_i", gnt, 4'b0000);
    check("sw_d_hold", d, 1'b1);

    // Requester 3 (next in rotation) is aborted by reset while in CHECK
    req = 4'b1000; wdata = 4'b1000;
    tick();
    check("ab_gnt", gnt, 4'b1000);
    tick();
    rst = 1'b1;
    #1;
    check("ab_gnt_rst", gnt, 4'b0000);
    check("ab_ack_rst", ack, 4'b0000);
    check("ab_d_rst", d, 1'b0);
    check("ab_busy_rst", busy, 1'b0);
    #2 rst = 1'b0;

    // Rotation after reset starts at 0; requester 3 re-requests and completes
    req = 4'b1111; wdata = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'b0001 << (k % 4);
      tick();
      check($sformatf("rr%0d_gnt", k), gnt, exp_gnt);
      check($sformatf("rr%0d_d", k), d, (k % 2 == 0) ? 1'b1 : 1'b0);
      tick();
      check($sformatf("rr%0d_q", k), q, (k % 2 == 0) ? 1'b1 : 1'b0);
      tick();
      check($sformatf("rr%0d_ack", k), ack, exp_gnt);
      if (k == 4) req = 4'b0000;
      tick();
      check($sformatf("rr%0d_busy", k), busy, 1'b0);
    end

    // q stuck at 0 while writing 1: three attempts, ack at N+7, sticky err
    stuck = 1'b1;
    req = 4'b0010; wdata = 4'b0010;
    tick();
    req = 4'b0000;
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("rt_c%0d_ack", c), ack, 4'b0000);
      check($sformatf("rt_c%0d_gnt", c), gnt, 4'b0010);
      check($sformatf("rt_c%0d_err", c), err, 1'b0);
      tick();
    end
    check("rt_ack", ack, 4'b0010);
    check("rt_err", err, 1'b1);
    tick();
    check("rt_busy_i", busy, 1'b0);
    check("rt_err_i", err, 1'b1);
    stuck = 1'b0;

    // A clean write afterwards leaves err set
    req = 4'b0100; wdata = 4'b0000;
    tick();
    check("cw_gnt", gnt, 4'b0100);
    check("cw_d", d, 1'b0);
    req = 4'b0000;
    tick(); tick();
    check("cw_ack", ack, 4'b0100);
    check("cw_err", err, 1'b1);
    tick();

`ifdef DFF_ARB_LOCK_EN
    rst = 1'b1;
    #2 rst = 1'b0;
    req = 4'b0011; wdata = 4'b0011; lock = 4'b0001;
    tick();
    check("lk_gnt0", gnt, 4'b0001);
    tick(); tick(); tick();
    tick();
    check("lk_gnt1", gnt, 4'b0001);
    lock = 4'b0000;
    tick(); tick(); tick();
    tick();
    check("lk_gnt2", gnt, 4'b0010);
    req = 4'b0000;
    tick(); tick(); tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/dff_share_arb.md
# dff_share_arb

Round-robin arbiter and write sequencer for one shared single-bit D flip-flop (`d`/`q` storage cell with `clk`/`reset`). Up to `NREQ` requesters each post a one-bit write. The block grants one requester at a time and drives the winner's bit onto the flop's `d` input. It then checks the flop's `q` one cycle later, retries on mismatch, and returns a per-requester acknowledge. It sits between requester logic and the shared flop, and is the only driver of the flop's `d`.

## Interface
Parameters:
- `NREQ`, default 4 — number of requesters; legal range 2..16.
- `RETRY_MAX`, default 2 — extra write attempts after a failed check; legal range 0..7.

Ports:
- `clk` — in, 1 — the single clock.
- `reset` — in, 1 — reset is asynchronous and active-high; shared with the flop.
- `req` — in, NREQ — `req[i]` requests a write by requester i.
- `wdata` — in, NREQ — `wdata[i]` is the bit requester i wants stored.
- `lock` — in, NREQ — grant-lock request. Present only with `DFF_ARB_LOCK_EN`.
- `gnt` — out, NREQ — one-hot grant, held for the whole transaction.
- `ack` — out, NREQ — one-cycle completion pulse to the granted requester.
- `err` — out, 1 — sticky; set when retries are exhausted.
- `busy` — out, 1 — high in any state other than IDLE.
- `d` — out, 1 — drives the shared flop's `d`.
- `q` — in, 1 — readback from the shared flop's `q`.

## Operation
- States: IDLE, WRITE, CHECK, RESP. All outputs are registered.
- **IDLE**
  - If `req` is nonzero, choose a winner by round-robin: search from index `ptr` upward, wrapping modulo NREQ.
  - Register `gnt` one-hot to the winner and load `d <= wdata[winner]`.
  - Clear the retry count and go to WRITE.
  - If `req` is zero, stay in IDLE; `d` holds its last value.
- **WRITE**
  - Lasts one cycle with `d` stable; the flop captures `d` at the end of this cycle.
  - Go to CHECK.
- **CHECK**
  - If `q == d`: go to RESP.
  - If `q != d` and retry count < RETRY_MAX: increment the count, re-drive `d` with the latched bit, and return to WRITE.
  - If `q != d` and retry count == RETRY_MAX: set `err`, then go to RESP. `ack` is still issued.
- **RESP**
  - `ack[winner]` is 1 for exactly this cycle.
  - Set `ptr <= winner+1` (mod NREQ), clear `gnt`, and go to IDLE.
- `wdata[winner]` is latched at grant. Later changes to `wdata` or `req` during the transaction are ignored. Dropping `req` does not abort the transaction.
- `d` changes only on a grant or a retry. Between transactions it holds the last written value, so the free-running flop keeps it.
- `err` clears only on `reset`.
- **Reset mid-transaction** (any state): asynchronously return to IDLE. No `ack` is issued for the aborted write; the requester must re-request.
- **Reset values:** state=IDLE, `gnt`=0, `ack`=0, `d`=0, `err`=0, `busy`=0, `ptr`=0, retry count=0.

## Timing
- Request seen in IDLE at cycle N:
  - `gnt` and `d` valid in cycle N+1 (WRITE).
  - `q` compared in cycle N+2 (CHECK).
  - `ack` high in cycle N+3 (RESP).
  - `busy` low and a new arbitration possible in cycle N+4.
- Each retry adds 2 cycles. Worst-case latency from request to `ack` is 3 + 2·RETRY_MAX cycles.
- Minimum spacing between consecutive grants is 4 cycles.
- A requester whose `req` is still high in the IDLE cycle after its `ack` is treated as a new request, at lowest priority under round-robin.
- `busy` is high from N+1 through N+3 inclusive.

## Configuration
- Macro: `DFF_ARB_LOCK_EN`.
- **Defined:** the `lock` port exists. If `lock[winner]` is 1 during RESP, `ptr` is not advanced and a lock flag is set. In the following IDLE cycle, if `req[winner]` is 1, the same requester is granted regardless of the round-robin order; otherwise normal arbitration applies. The lock flag is cleared on any grant made with `lock[winner]` = 0, and on `reset`.
- **Undefined:** the `lock` port is absent and arbitration is pure round-robin.

## Test plan
- **Reset values:** assert `reset` mid-simulation → `gnt`=0, `ack`=0, `d`=0, `err`=0, `busy`=0 immediately (asynchronous); first grant after reset goes to requester 0 when `req`=4'b1111.
- **Single write latency:** `req`=4'b0100 and `wdata[2]`=1 at cycle N → `gnt`=4'b0100 and `d`=1 at N+1; flop `q`=1 at N+2; `ack`=4'b0100 at N+3 only; `err`=0.
- **Round-robin rotation:** `req`=4'b1111 held high, alternating `wdata` → grants in order 0,1,2,3,0, each 4 cycles apart; `q` tracks each written bit.
- **Retry and error (RETRY_MAX=2):** force `q` stuck at 0 while writing 1 → WRITE/CHECK repeated 3 times; `ack` at cycle N+7; `err`=1 and it stays set.
- **Reset abort:** assert `reset` while in CHECK → no `ack`, `ptr`=0, `busy`=0; the requester re-requests and completes normally.
- **Grant lock (DFF_ARB_LOCK_EN):** `req`=4'b0011 with `lock[0]`=1 → requester 0 is granted twice in a row; with `lock[0]` dropped, the next grant goes to requester 1.
